// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Covers FSM states, opcodes, immediate-select and datapath mux/ALU codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, TRAP
    } state_t;

    // Tells the ALU decoder what kind of operation the current state needs.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_FUNC
    } alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode for the multi-cycle control unit.
// Also flags R/I arithmetic encodings the datapath cannot execute (sltu, sra/srai).
module mc_alu_decoder
    import riscv_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [2:0]  alu_ctrl,
    output logic        illegal_alu
);

    logic is_arith;

    // Select the ALU operation from the state class and funct fields.
    always_comb begin
        alu_ctrl    = ALU_ADD;
        illegal_alu = 1'b0;
        is_arith    = (op == OP_RTYPE) || (op == OP_ITYPE);

        if (is_arith) begin
            if (funct3 == 3'b011)
                illegal_alu = 1'b1;
            if ((funct3 == 3'b101) && funct7b5)
                illegal_alu = 1'b1;
        end

        case (cls)
            CLS_SUB:  alu_ctrl = ALU_SUB;
            CLS_FUNC: begin
                case (funct3)
                    3'b000:  alu_ctrl = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b101:  alu_ctrl = ALU_SRL;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default:  alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences the shared datapath one instruction
// at a time with a ready-based handshake on the unified memory port.
// Optional feature: define MC_INSTRET_EN to enable the retired-instruction counter;
// otherwise instret is tied to zero.
module mc_control_fsm
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  imm_src,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    alu_cls_t    alu_cls;
    logic        illegal_q, illegal_alu;
    logic [2:0]  alu_ctrl_c;
    logic        mem_req_c, mem_write_c, adr_src_c;
    logic        ir_write_c, pc_write_c, reg_write_c;
    logic [1:0]  alu_src_a_c, alu_src_b_c, result_src_c, imm_src_c;
    logic [31:0] instret_q;

    mc_alu_decoder u_alu_dec (
        .cls         (alu_cls),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_ctrl    (alu_ctrl_c),
        .illegal_alu (illegal_alu)
    );

    // State register and sticky trap flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP)
                illegal_q <= 1'b1;
        end
    end

    // Next-state and datapath control for the current state.
    always_comb begin
        state_d      = state_q;
        alu_cls      = CLS_ADD;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        result_src_c = RES_ALUOUT;

        case (state_q)
            FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:  state_d = illegal_alu ? TRAP : EXECR;
                    OP_ITYPE:  state_d = illegal_alu ? TRAP : EXECI;
                    OP_BRANCH: state_d = ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) ? BRANCH : TRAP;
                    default:   state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready)
                    state_d = MEMWB;
            end
            MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready)
                    state_d = FETCH;
            end
            EXECR: begin
                alu_cls     = CLS_FUNC;
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_cls     = CLS_FUNC;
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_cls     = CLS_SUB;
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                pc_write_c  = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
                state_d     = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE:  imm_src_c = IMM_S;
            OP_BRANCH: imm_src_c = IMM_B;
            default:   imm_src_c = IMM_I;
        endcase
    end

`ifdef MC_INSTRET_EN
    logic retire;
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                    ((state_q == MEMWRITE) && mem_ready);

    // Count retired instructions; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n)
            instret_q <= 32'd0;
        else if (retire)
            instret_q <= instret_q + 32'd1;
    end
`else
    assign instret_q = 32'd0;
`endif

    // Every output reads as zero while reset is held.
    assign mem_req    = rst_n & mem_req_c;
    assign mem_write  = rst_n & mem_write_c;
    assign adr_src    = rst_n & adr_src_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
    assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
    assign result_src = rst_n ? result_src_c : 2'b00;
    assign alu_ctrl   = rst_n ? alu_ctrl_c   : ALU_ADD;
    assign imm_src    = rst_n ? imm_src_c    : IMM_I;
    assign illegal    = rst_n & illegal_q;
    assign instret    = rst_n ? instret_q    : 32'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with an instruction-level expectation model.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  alu_ctrl;
    logic        illegal;
    logic [31:0] instret;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_ctrl(alu_ctrl), .imm_src(imm_src), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, BAD = 7'b1111111;
    localparam logic B0 = 1'b0, B1 = 1'b1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        chk = 1'b0;
    logic [17:0] exp_v;
    logic [31:0] exp_ir;
    logic [31:0] ret_cnt = 32'd0;
    string       tag;
    logic [17:0] act_v;

    assign act_v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, illegal};

    // Field order: req,wr,adr,irw,pcw,rw | srcA,srcB,res | alu | imm | illegal
    function automatic logic [17:0] mk(input logic rq, input logic wr, input logic ad,
                                       input logic iw, input logic pw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [2:0] alu,
                                       input logic [1:0] im, input logic il);
        return {rq, wr, ad, iw, pw, rw, a, b, res, alu, im, il};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BR) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b001:  return 3'b110;
            3'b101:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic legal_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (o == LW || o == SW) return 1'b1;
        if (o == BR) return (f3 == 3'b000 || f3 == 3'b001);
        if (o == RT || o == IT) return !(f3 == 3'b011 || (f3 == 3'b101 && f7));
        return 1'b0;
    endfunction

    // Single compare process: checks every flagged cycle on the falling edge.
    always @(negedge clk) begin
        if (chk) begin
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s: outputs got %h want %h", tag, act_v, exp_v);
            end
            n_cmp++;
            if (instret !== exp_ir) begin
                n_err++;
                $display("FAIL %s_instret: got %h want %h", tag, instret, exp_ir);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input logic [17:0] e, input logic rdy, input string t);
        mem_ready = rdy;
        exp_v = e;
`ifdef MC_INSTRET_EN
        exp_ir = ret_cnt;
`else
        exp_ir = 32'd0;
`endif
        tag = t;
        chk = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step(input string t);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        exp_v = 18'd0;
        exp_ir = 32'd0;
        tag = t;
        chk = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_cnt = 32'd0;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input logic abort,
                             output int cycles);
        logic [1:0] im;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        im = imm_of(o);
        cycles = 0;
        for (int i = 0; i < fw; i++) begin
            step(mk(B1,B0,B0,B0,B0,B0,2'b00,2'b10,2'b10,3'b000,im,B0), B0, "fetch_wait");
            cycles++;
        end
        step(mk(B1,B0,B0,B1,B1,B0,2'b00,2'b10,2'b10,3'b000,im,B0), B1, "fetch");
        cycles++;
        step(mk(B0,B0,B0,B0,B0,B0,2'b01,2'b01,2'b00,3'b000,im,B0), B1, "decode");
        cycles++;
        if (!legal_of(o, f3, f7)) begin
            for (int i = 0; i < 2; i++)
                step(mk(B0,B0,B0,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,im,B1), B1, "trap");
            return;
        end
        if (o == LW || o == SW) begin
            step(mk(B0,B0,B0,B0,B0,B0,2'b10,2'b01,2'b00,3'b000,im,B0), B1, "memadr");
            cycles++;
            if (abort) begin
                rst_step("reset_in_mem");
                return;
            end
            for (int i = 0; i < mw; i++) begin
                step(mk(B1,(o == SW),B1,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,im,B0), B0, "mem_wait");
                cycles++;
            end
            step(mk(B1,(o == SW),B1,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,im,B0), B1, "mem_done");
            cycles++;
            if (o == LW) begin
                step(mk(B0,B0,B0,B0,B0,B1,2'b00,2'b00,2'b01,3'b000,im,B0), B1, "memwb");
                cycles++;
            end
        end else if (o == RT || o == IT) begin
            step(mk(B0,B0,B0,B0,B0,B0,2'b10,(o == RT) ? 2'b00 : 2'b01,2'b00,alu_of(o,f3,f7),im,B0),
                 B1, "exec");
            cycles++;
            step(mk(B0,B0,B0,B0,B0,B1,2'b00,2'b00,2'b00,3'b000,im,B0), B1, "aluwb");
            cycles++;
        end else begin
            step(mk(B0,B0,B0,B0,(f3 == 3'b000) ? z : !z,B0,2'b10,2'b00,2'b00,3'b001,im,B0),
                 B1, "branch");
            cycles++;
        end
        ret_cnt = ret_cnt + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n = 1'b0; op = IT; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_step("reset");

        // Literal pins on the very first FETCH cycle.
        mem_ready = 1'b0;
        #1;
        lit("fetch_mem_req", mem_req, 1);
        lit("fetch_no_irw", ir_write, 0);
        lit("fetch_srcb", alu_src_b, 2);

        run_instr(IT, 3'b000, B0, B0, 0, 0, B0, c); lit("addi_cycles", c, 4);
        run_instr(LW, 3'b010, B0, B0, 2, 1, B0, c); lit("lw_wait_cycles", c, 8);
        run_instr(LW, 3'b010, B0, B0, 0, 0, B0, c); lit("lw_cycles", c, 5);
        run_instr(BR, 3'b000, B0, B1, 0, 0, B0, c); lit("beq_taken_cycles", c, 3);
        run_instr(BR, 3'b000, B0, B0, 0, 0, B0, c);
        run_instr(BR, 3'b001, B0, B0, 0, 0, B0, c);
        run_instr(BR, 3'b001, B0, B1, 0, 0, B0, c);
        run_instr(SW, 3'b010, B0, B0, 0, 0, B0, c); lit("sw_cycles", c, 4);
        run_instr(SW, 3'b010, B0, B0, 0, 2, B0, c); lit("sw_wait_cycles", c, 6);
        run_instr(RT, 3'b000, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b000, B1, B0, 0, 0, B0, c);
        run_instr(RT, 3'b111, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b110, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b100, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b010, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b001, B0, B0, 0, 0, B0, c);
        run_instr(RT, 3'b101, B0, B0, 0, 0, B0, c);
        run_instr(IT, 3'b000, B1, B0, 0, 0, B0, c);
        run_instr(IT, 3'b100, B0, B0, 1, 0, B0, c); lit("xori_wait_cycles", c, 5);

        run_instr(BAD, 3'b000, B0, B0, 0, 0, B0, c);
        lit("trap_sticky", illegal, 1);
        rst_step("reset_after_trap");
        lit("illegal_cleared", illegal, 0);
        run_instr(RT, 3'b101, B1, B0, 0, 0, B0, c);
        rst_step("reset_after_sra");
        run_instr(RT, 3'b011, B0, B0, 0, 0, B0, c);
        rst_step("reset_after_sltu");
        run_instr(IT, 3'b101, B1, B0, 0, 0, B0, c);
        rst_step("reset_after_srai");
        run_instr(BR, 3'b010, B0, B0, 0, 0, B0, c);
        rst_step("reset_after_badbr");

        run_instr(IT, 3'b000, B0, B0, 0, 0, B0, c);
        run_instr(LW, 3'b010, B0, B0, 0, 0, B1, c);
        run_instr(IT, 3'b110, B0, B0, 0, 0, B0, c);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
